uart_rx_os16: RTL and testbench

Standalone UART receiver with 16x oversampling, mid-bit sampling, start-bit glitch rejection and framing/parity/overrun detection. It is the receive end of the 8-bit UART link whose transmitter drives a 1-start / 8-data (LSB first) / optional-parity / 1-stop serial line. It sits between the external `rx_in` pin and a byte consumer using a valid/ready handshake. It replaces the fixed-baud receive path with a parameterised divider.

---
 rtl/uart_rx_os16.sv | 215 +++++++++++++++++++++
 tb/tb_uart_rx_os16.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: UART receiver, 16x oversampling, mid-bit sampling, start-bit glitch
// rejection, framing/parity/overrun detection, valid/ready byte output.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> 8E1 frames, PARITY state present, parity_err reports even-parity mismatch
//   undefined -> 8N1 frames, no parity logic, parity_err tied to 0
//
// Parameters:
//   CLK_DIV      clock cycles per oversample tick (2..65535)
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   rx_in        serial line, asynchronous, idle high
//   rx_data      received byte
//   rx_valid     rx_data and error flags valid, held until accepted
//   rx_ready     consumer accepts when rx_valid & rx_ready
//   parity_err   even-parity mismatch for the held byte
//   frame_err    stop bit sampled low for the held byte
//   overrun_err  a frame completed while the previous byte was unaccepted (sticky)
//   busy         receiver FSM not idle
module uart_rx_os16 #(
  parameter int unsigned CLK_DIV = 326
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       busy
);

  localparam logic [15:0] PrescMax = 16'(CLK_DIV - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e state_q, state_d;

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        prev_q, prev_d;
  logic [15:0] presc_q, presc_d;
  logic [3:0]  tcnt_q, tcnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;

  logic sample;
  logic fall;
  logic tick;
  logic mid_start;
  logic bit_end;
  logic frame_done;
  logic handshake;

  assign sample     = sync2_q;
  assign fall       = prev_q & ~sync2_q;
  assign tick       = (presc_q == PrescMax);
  assign mid_start  = tick & (tcnt_q == 4'd7);
  assign bit_end    = tick & (tcnt_q == 4'd15);
  assign frame_done = (state_q == StStop) & bit_end;
  assign handshake  = rx_valid_q & rx_ready;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (fall) state_d = StStart;
      // Line back high at mid-start means a glitch: drop it silently.
      StStart: if (mid_start) state_d = sample ? StIdle : StData;
      StData: begin
        if (bit_end && (bit_cnt_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: if (bit_end) state_d = StStop;
`endif
      // Leave at mid-stop so a back-to-back start edge is not missed.
      StStop:  if (bit_end) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != StIdle);
  end

`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d;
  logic parity_err_q, parity_err_d;

  always_comb begin
    perr_d = perr_q;
    if ((state_q == StParity) && bit_end) perr_d = ^{shift_q, sample};
    parity_err_d = parity_err_q;
    if (frame_done) parity_err_d = perr_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perr_q       <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      perr_q       <= perr_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  // Datapath next-state
  always_comb begin
    sync1_d = rx_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;

    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    tcnt_d  = tick ? tcnt_q + 4'd1 : tcnt_q;
    // Realign the bit timing to the detected start edge.
    if ((state_q == StIdle) && fall) begin
      presc_d = 16'd0;
      tcnt_d  = 4'd0;
    end
    // Restart the tick count at mid-start so tick 15 lands mid-bit.
    if ((state_q == StStart) && mid_start && !sample) tcnt_d = 4'd0;

    bit_cnt_d = 3'd0;
    shift_d   = shift_q;
    if (state_q == StData) begin
      bit_cnt_d = bit_cnt_q;
      if (bit_end) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        shift_d   = {sample, shift_q[7:1]};
      end
    end

    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    if (handshake) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
    if (frame_done) begin
      rx_data_d   = shift_q;
      frame_err_d = ~sample;
      rx_valid_d  = 1'b1;
      // A simultaneous handshake frees the slot, so no overrun then.
      overrun_d   = rx_valid_q & ~rx_ready;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      presc_q     <= 16'd0;
      tcnt_q      <= 4'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      presc_q     <= presc_d;
      tcnt_q      <= tcnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb_uart_rx_os16: directed frames into uart_rx_os16 (CLK_DIV=4); expected bytes are
// queued at send time and a forked monitor compares them when the DUT hands a byte over.
module tb_uart_rx_os16;

  localparam int unsigned ClkDiv = 4;
  localparam int unsigned BitCyc = 16 * ClkDiv;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rx_in = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  uart_rx_os16 #(.CLK_DIV(ClkDiv)) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_in       (rx_in),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       oerr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   edge_cyc = 0;
  int   rise_cyc = 0;
  int   valid_hi = 0;
  logic valid_prev = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (rx_valid && !valid_prev) rise_cyc = cyc;
    if (rx_valid) valid_hi = valid_hi + 1;
    valid_prev = rx_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset && rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %0h want none", rx_data);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
          check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
          check("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
          check("overrun_err", {31'd0, overrun_err}, {31'd0, e.oerr});
        end
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx_in = v;
    wait_cyc(BitCyc);
  endtask

  // par is the transmitted parity bit (ignored on the line in 8N1 builds).
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input logic oerr, input logic push, input int gap);
    logic perr_exp;
    perr_exp = ^{d, par};
`ifndef UART_RX_PARITY_EN
    perr_exp = 1'b0;
`endif
    if (push) exp_q.push_back('{data: d, perr: perr_exp, ferr: ~stop, oerr: oerr});
    edge_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`endif
    drive_bit(stop);
    rx_in = 1'b1;
    if (gap > 0) wait_cyc(gap);
  endtask

  initial begin
    int   lat;
    int   v0;
    logic seen;
    fork
      monitor();
    join_none

    // Reset state
    wait_cyc(3);
    check("rst_rx_data", {24'd0, rx_data}, 32'h00);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_overrun_err", {31'd0, overrun_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    wait_cyc(5);

    // 0xA5, ready high: one-cycle valid pulse, latency 608 +- 4
    v0 = valid_hi;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 2 * BitCyc);
    lat = rise_cyc - edge_cyc;
    total++;
    if (lat < 604 || lat > 612) begin
      bad++;
      $display("FAIL latency: got %0d want 604..612", lat);
    end
    check("valid_pulse_cycles", valid_hi - v0, 32'd1);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 2 * BitCyc);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 2 * BitCyc);
`endif

    // Framing error then a clean frame
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 2 * BitCyc);
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 2 * BitCyc);

    // 20-cycle start glitch: busy pulses, nothing delivered
    v0 = valid_hi;
    seen = 1'b0;
    rx_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wait_cyc(1);
      if (busy) seen = 1'b1;
    end
    rx_in = 1'b1;
    wait_cyc(60);
    check("glitch_busy_pulsed", {31'd0, seen}, 32'd1);
    check("glitch_busy_cleared", {31'd0, busy}, 32'd0);
    check("glitch_no_valid", valid_hi - v0, 32'd0);
    send_frame(8'h77, 1'b0, 1'b1, 1'b0, 1'b1, 2 * BitCyc);

    // Overrun: two frames back-to-back with ready low
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 0);
    check("ovr_valid_held", {31'd0, rx_valid}, 32'd1);
    check("ovr_flag_set", {31'd0, overrun_err}, 32'd1);
    check("ovr_data_newest", {24'd0, rx_data}, 32'h22);
    rx_ready = 1'b1;
    wait_cyc(1);
    check("ovr_valid_cleared", {31'd0, rx_valid}, 32'd0);
    check("ovr_flag_cleared", {31'd0, overrun_err}, 32'd0);
    wait_cyc(2 * BitCyc);

    // Reset in the middle of 0xFF
    rx_in = 1'b0;
    wait_cyc(BitCyc);
    rx_in = 1'b1;
    wait_cyc(2 * BitCyc);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_rx_data", {24'd0, rx_data}, 32'h00);
    check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("midrst_parity_err", {31'd0, parity_err}, 32'd0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    check("midrst_overrun_err", {31'd0, overrun_err}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(6 * BitCyc);
    check("post_rst_idle", {31'd0, busy}, 32'd0);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 2 * BitCyc);

    // Drain the scoreboard
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) wait_cyc(1);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
